// File: rtl/search_scheduler_if.sv
// Handshake bundle between host job sources, the search scheduler and the
// shared pattern-search engine. The scheduler sits on the slave modport.
interface search_scheduler_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_p;
    logic [8*NREQ-1:0] req_pl;
    logic [8*NREQ-1:0] req_b;
    logic [8*NREQ-1:0] req_bl;

    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [7:0]        res_addr;
    logic              res_hit;
    logic              res_last;
    logic              res_trunc;
    logic              res_err;

    logic [7:0]        eng_p;
    logic [7:0]        eng_pl;
    logic [7:0]        eng_b;
    logic [7:0]        eng_bl;
    logic              eng_reset;
    logic              eng_activate;
    logic              eng_done;
    logic [7:0]        eng_found;

    modport master (
        output req_valid, req_p, req_pl, req_b, req_bl, res_ready, eng_done, eng_found,
        input  req_ready, res_valid, res_id, res_addr, res_hit, res_last, res_trunc,
               res_err, eng_p, eng_pl, eng_b, eng_bl, eng_reset, eng_activate
    );

    modport slave (
        input  req_valid, req_p, req_pl, req_b, req_bl, res_ready, eng_done, eng_found,
        output req_ready, res_valid, res_id, res_addr, res_hit, res_last, res_trunc,
               res_err, eng_p, eng_pl, eng_b, eng_bl, eng_reset, eng_activate
    );
endinterface

// File: rtl/search_scheduler.sv
// Round-robin scheduler sharing one pattern-search engine between NREQ requesters.
// Optional watchdog on RUN/DRAIN enabled by defining SEARCH_TIMEOUT_EN.
module search_scheduler #(
    parameter int         NREQ     = 2,
    parameter int         IDW      = 2,
    parameter logic [7:0] NOMATCH  = 8'hFF,
    parameter int         MAX_HITS = 16,
    parameter int         TIMEOUT  = 1023
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    search_scheduler_if.slave  bus,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, CHECK, LOAD, RUN, HIT, DRAIN, TERM} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [7:0]     lp, lpl, lb, lbl;
    logic [7:0]     hits;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [7:0]     sel_p, sel_pl, sel_b, sel_bl;

`ifdef SEARCH_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd;
`endif

    assign busy = (state != IDLE);

    // Search order starts one past the last granted requester.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_p       = '0;
        sel_pl      = '0;
        sel_b       = '0;
        sel_bl      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!grant_found && j == (int'(ptr) + i) % NREQ && bus.req_valid[j]) begin
                    grant_found = 1'b1;
                    grant_idx   = IDW'(j);
                    sel_p       = bus.req_p[8*j +: 8];
                    sel_pl      = bus.req_pl[8*j +: 8];
                    sel_b       = bus.req_b[8*j +: 8];
                    sel_bl      = bus.req_bl[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            ptr              <= '0;
            lp               <= '0;
            lpl              <= '0;
            lb               <= '0;
            lbl              <= '0;
            hits             <= '0;
            bus.req_ready    <= '0;
            bus.res_valid    <= 1'b0;
            bus.res_id       <= '0;
            bus.res_addr     <= '0;
            bus.res_hit      <= 1'b0;
            bus.res_last     <= 1'b0;
            bus.res_trunc    <= 1'b0;
            bus.res_err      <= 1'b0;
            bus.eng_p        <= '0;
            bus.eng_pl       <= '0;
            bus.eng_b        <= '0;
            bus.eng_bl       <= '0;
            bus.eng_reset    <= 1'b0;
            bus.eng_activate <= 1'b0;
`ifdef SEARCH_TIMEOUT_EN
            wd               <= '0;
`endif
        end else begin
            // NOTE: state updates use non-blocking assignments so every branch sees pre-edge values.
            bus.req_ready <= '0;
            bus.eng_reset <= 1'b0;
`ifdef SEARCH_TIMEOUT_EN
            wd            <= '0;
`endif
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.req_ready <= NREQ'(1) << grant_idx;
                        ptr           <= grant_idx;
                        bus.res_id    <= grant_idx;
                        lp            <= sel_p;
                        lpl           <= sel_pl;
                        lb            <= sel_b;
                        lbl           <= sel_bl;
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    if (lpl == 8'd0 || lbl == 8'd0 || lpl > lbl) begin
                        bus.res_err   <= 1'b1;
                        bus.res_valid <= 1'b1;
                        bus.res_last  <= 1'b1;
                        bus.res_hit   <= 1'b0;
                        bus.res_addr  <= '0;
                        state         <= TERM;
                    end else begin
                        bus.eng_p     <= lp;
                        bus.eng_pl    <= lpl;
                        bus.eng_b     <= lb;
                        bus.eng_bl    <= lbl;
                        bus.eng_reset <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    hits             <= '0;
                    bus.eng_activate <= 1'b1;
                    state            <= RUN;
                end
                RUN: begin
                    if (bus.eng_done) begin
                        bus.eng_activate <= 1'b0;
                        bus.res_valid    <= 1'b1;
                        if (bus.eng_found == NOMATCH) begin
                            bus.res_hit  <= 1'b0;
                            bus.res_last <= 1'b1;
                            bus.res_addr <= '0;
                            state        <= TERM;
                        end else begin
                            bus.res_hit  <= 1'b1;
                            bus.res_addr <= bus.eng_found;
                            state        <= HIT;
                        end
                    end
`ifdef SEARCH_TIMEOUT_EN
                    else if (wd == WDW'(TIMEOUT - 1)) begin
                        bus.eng_activate <= 1'b0;
                        bus.res_valid    <= 1'b1;
                        bus.res_hit      <= 1'b0;
                        bus.res_last     <= 1'b1;
                        bus.res_err      <= 1'b1;
                        bus.res_addr     <= '0;
                        state            <= TERM;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                HIT: begin
                    if (bus.res_ready) begin
                        hits <= hits + 8'd1;
                        if (hits + 8'd1 == 8'(MAX_HITS)) begin
                            bus.res_hit   <= 1'b0;
                            bus.res_last  <= 1'b1;
                            bus.res_trunc <= 1'b1;
                            bus.res_addr  <= '0;
                            state         <= TERM;
                        end else begin
                            bus.res_valid <= 1'b0;
                            bus.res_hit   <= 1'b0;
                            state         <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The engine must drop done before it may be asked to continue.
                    if (!bus.eng_done) begin
                        bus.eng_activate <= 1'b1;
                        state            <= RUN;
                    end
`ifdef SEARCH_TIMEOUT_EN
                    else if (wd == WDW'(TIMEOUT - 1)) begin
                        bus.res_valid <= 1'b1;
                        bus.res_hit   <= 1'b0;
                        bus.res_last  <= 1'b1;
                        bus.res_err   <= 1'b1;
                        bus.res_addr  <= '0;
                        state         <= TERM;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                TERM: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.res_last  <= 1'b0;
                        bus.res_trunc <= 1'b0;
                        bus.res_err   <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_search_scheduler.sv
// Randomized bench for search_scheduler: engine model plus a job-level reference
// model that predicts arbitration order and every result record.
module tb_search_scheduler;
    localparam int         NREQ = 3;
    localparam int         IDW  = 2;
    localparam int         MAXH = 3;
    localparam logic [7:0] NOM  = 8'hFF;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     addr;
        logic           hit;
        logic           last;
        logic           trunc;
        logic           err;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    search_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus();

    search_scheduler #(
        .NREQ(NREQ), .IDW(IDW), .NOMATCH(NOM), .MAX_HITS(MAXH), .TIMEOUT(40)
    ) dut (
        .CLK100MHZ(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy)
    );

    // Job descriptors and engine scripts, one per requester.
    logic [7:0] jp [NREQ];
    logic [7:0] jpl[NREQ];
    logic [7:0] jb [NREQ];
    logic [7:0] jbl[NREQ];
    logic [7:0] scr[NREQ][8];
    int         slen[NREQ];

    rec_t exp_q[$];
    int   accept_order[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   rr_ptr = 0;
    int   cur_job = 0;
    int   n_eng_reset = 0, exp_eng_reset = 0;
    int   n_act_rise = 0, exp_act_rise = 0;
    int   ready_mode = 0;
    bit   eng_stall = 1'b0;
    bit   prev_act = 1'b0;
    bit   stalled = 1'b0;
    rec_t snap;
    logic [NREQ-1:0] clear_mask = '0;

    // Engine model: answers each activate after 0..2 cycles, holds done until activate drops.
    int eidx, edly;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.eng_done  <= 1'b0;
            bus.eng_found <= 8'h00;
            eidx          <= 0;
            edly          <= 0;
        end else if (bus.eng_reset) begin
            bus.eng_done <= 1'b0;
            eidx         <= 0;
            edly         <= 0;
        end else if (!bus.eng_activate) begin
            bus.eng_done <= 1'b0;
        end else if (!bus.eng_done && !eng_stall) begin
            if (edly == 0) begin
                bus.eng_done  <= 1'b1;
                bus.eng_found <= (eidx < slen[cur_job]) ? scr[cur_job][eidx] : NOM;
                eidx          <= eidx + 1;
                edly          <= $urandom_range(0, 2);
            end else begin
                edly <= edly - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic rec_t cur_rec();
        return '{bus.res_id, bus.res_addr, bus.res_hit, bus.res_last, bus.res_trunc, bus.res_err};
    endfunction

    // Reference model: expand one accepted job into its full record sequence.
    task automatic model_job(int k);
        int   n;
        int   nh;
        bit   fin;
        logic [7:0] v;
        if (jpl[k] == 0 || jbl[k] == 0 || jpl[k] > jbl[k]) begin
            exp_q.push_back('{IDW'(k), 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
        end else begin
            exp_eng_reset++;
            n = 0; nh = 0; fin = 1'b0;
            while (!fin) begin
                exp_act_rise++;
                v = (n < slen[k]) ? scr[k][n] : NOM;
                n++;
                if (v == NOM) begin
                    exp_q.push_back('{IDW'(k), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
                    fin = 1'b1;
                end else begin
                    exp_q.push_back('{IDW'(k), v, 1'b1, 1'b0, 1'b0, 1'b0});
                    nh++;
                    if (nh == MAXH) begin
                        exp_q.push_back('{IDW'(k), 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
                        fin = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic submit(int k, logic [7:0] p, logic [7:0] pl, logic [7:0] b, logic [7:0] bl,
                          int len, logic [63:0] vals);
        jp[k] = p; jpl[k] = pl; jb[k] = b; jbl[k] = bl; slen[k] = len;
        for (int n = 0; n < 8; n++) scr[k][n] = vals[8*n +: 8];
        bus.req_p[8*k +: 8]  = p;
        bus.req_pl[8*k +: 8] = pl;
        bus.req_b[8*k +: 8]  = b;
        bus.req_bl[8*k +: 8] = bl;
        bus.req_valid[k]     = 1'b1;
    endtask

    // One clock: sample and check at negedge, drive inputs just after posedge.
    task automatic step();
        int   eg;
        rec_t got, e;
        @(negedge clk);
        if (bus.req_ready != '0) begin
            vectors++;
            if (!$onehot(bus.req_ready)) begin
                miscompares++;
                $display("FAIL req_ready_onehot: got %b required one-hot", bus.req_ready);
            end
            eg = -1;
            for (int i = 1; i <= NREQ; i++)
                if (eg < 0 && bus.req_valid[(rr_ptr + i) % NREQ]) eg = (rr_ptr + i) % NREQ;
            for (int k = 0; k < NREQ; k++) begin
                if (bus.req_ready[k]) begin
                    vectors++;
                    if (k != eg) begin
                        miscompares++;
                        $display("FAIL rr_grant: got %0d required %0d", k, eg);
                    end
                    rr_ptr = k; cur_job = k;
                    accept_order.push_back(k);
                    clear_mask[k] = 1'b1;
                    model_job(k);
                end
            end
        end
        if (bus.eng_reset) begin
            n_eng_reset++;
            vectors++;
            if ({bus.eng_p, bus.eng_pl, bus.eng_b, bus.eng_bl} !==
                {jp[cur_job], jpl[cur_job], jb[cur_job], jbl[cur_job]}) begin
                miscompares++;
                $display("FAIL eng_fields: got %h required %h",
                         {bus.eng_p, bus.eng_pl, bus.eng_b, bus.eng_bl},
                         {jp[cur_job], jpl[cur_job], jb[cur_job], jbl[cur_job]});
            end
        end
        if (bus.eng_activate && !prev_act) begin
            n_act_rise++;
            vectors++;
            if (bus.eng_done) begin
                miscompares++;
                $display("FAIL activate_while_done: got done=1 required done=0");
            end
        end
        prev_act = bus.eng_activate;
        got = cur_rec();
        if (stalled) begin
            vectors++;
            if (bus.res_valid !== 1'b1 || got !== snap) begin
                miscompares++;
                $display("FAIL res_stable: got v=%b %h required v=1 %h", bus.res_valid, got, snap);
            end
        end
        stalled = bus.res_valid && !bus.res_ready;
        snap = got;
        if (bus.res_valid && bus.res_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_record: got %h required none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL record: got id=%0d addr=%h hit=%b last=%b trunc=%b err=%b required id=%0d addr=%h hit=%b last=%b trunc=%b err=%b",
                             got.id, got.addr, got.hit, got.last, got.trunc, got.err,
                             e.id, e.addr, e.hit, e.last, e.trunc, e.err);
                end
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~clear_mask;
        clear_mask = '0;
        case (ready_mode)
            0:       bus.res_ready = 1'b1;
            1:       bus.res_ready = ($urandom_range(0, 3) != 0);
            default: bus.res_ready = 1'b0;
        endcase
    endtask

    task automatic run_until_done(string name, int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || bus.req_valid != '0 || busy) && c < budget) begin
            step();
            c++;
        end
        vectors++;
        if (c >= budget) begin
            miscompares++;
            $display("FAIL %s_budget: got %0d cycles, %0d records pending, required completion",
                     name, c, exp_q.size());
        end
        vectors++;
        if (n_eng_reset != exp_eng_reset) begin
            miscompares++;
            $display("FAIL %s_eng_reset_count: got %0d required %0d", name, n_eng_reset, exp_eng_reset);
        end
        vectors++;
        if (n_act_rise != exp_act_rise) begin
            miscompares++;
            $display("FAIL %s_activate_count: got %0d required %0d", name, n_act_rise, exp_act_rise);
        end
    endtask

    task automatic check_all_zero(string name);
        logic [63:0] outs;
        outs = {bus.req_ready, bus.res_valid, bus.res_id, bus.res_addr, bus.res_hit, bus.res_last,
                bus.res_trunc, bus.res_err, bus.eng_p, bus.eng_pl, bus.eng_b, bus.eng_bl,
                bus.eng_reset, bus.eng_activate, busy};
        vectors++;
        if (outs !== 64'd0) begin
            miscompares++;
            $display("FAIL %s: got outputs %h required 0", name, outs);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.req_p = '0; bus.req_pl = '0; bus.req_b = '0; bus.req_bl = '0;
        bus.res_ready = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_basic_hits();
        ready_mode = 0;
        submit(0, 8'd0, 8'd2, 8'd0, 8'd20, 2, {48'h0, 8'd12, 8'd5});
        run_until_done("basic_hits", 200);
    endtask

    task automatic test_arbitration();
        accept_order.delete();
        ready_mode = 1;
        submit(0, 8'd1, 8'd1, 8'd2, 8'd4, 0, 64'h0);
        submit(1, 8'd3, 8'd2, 8'd5, 8'd9, 1, 64'h21);
        run_until_done("arbitration", 300);
        vectors++;
        if (accept_order.size() != 2 || accept_order[0] != 1 || accept_order[1] != 0) begin
            miscompares++;
            $display("FAIL arb_order: got %p required '{1,0}", accept_order);
        end
    endtask

    task automatic test_truncation();
        ready_mode = 1;
        submit(2, 8'd4, 8'd3, 8'd0, 8'd30, 5, {24'h0, 8'd11, 8'd10, 8'd9, 8'd4, 8'd3});
        run_until_done("truncation", 300);
    endtask

    task automatic test_reject();
        ready_mode = 0;
        submit(1, 8'd0, 8'd5, 8'd0, 8'd3, 2, {48'h0, 8'd1, 8'd2});
        run_until_done("reject_pl_gt_bl", 100);
        submit(0, 8'd0, 8'd0, 8'd0, 8'd4, 0, 64'h0);
        run_until_done("reject_pl_zero", 100);
        submit(2, 8'd0, 8'd3, 8'd0, 8'd0, 0, 64'h0);
        run_until_done("reject_bl_zero", 100);
        submit(1, 8'd0, 8'd6, 8'd0, 8'd6, 0, 64'h0);
        run_until_done("accept_pl_eq_bl", 100);
    endtask

    task automatic test_backpressure();
        int c;
        ready_mode = 2;
        submit(0, 8'd2, 8'd2, 8'd0, 8'd16, 1, 64'h07);
        c = 0;
        while (!(bus.res_valid && bus.res_hit) && c < 60) begin
            step();
            c++;
        end
        for (int n = 0; n < 10; n++) begin
            step();
            vectors++;
            if (bus.res_addr !== 8'h07 || bus.eng_activate !== 1'b0 || bus.res_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_record: got addr=%h act=%b valid=%b required addr=07 act=0 valid=1",
                         bus.res_addr, bus.eng_activate, bus.res_valid);
            end
        end
        ready_mode = 0;
        run_until_done("backpressure", 100);
    endtask

    task automatic test_random();
        logic [63:0] vals;
        int          len;
        ready_mode = 1;
        for (int r = 0; r < 14; r++) begin
            for (int k = 0; k < NREQ; k++) begin
                if ($urandom_range(0, 1) == 1 || k == r % NREQ) begin
                    len = $urandom_range(0, 5);
                    for (int n = 0; n < 8; n++) vals[8*n +: 8] = 8'($urandom_range(0, 254));
                    submit(k, 8'($urandom), 8'($urandom_range(0, 10)), 8'($urandom),
                           8'($urandom_range(0, 20)), len, vals);
                end
            end
            run_until_done("random", 600);
        end
    endtask

    task automatic test_reset_mid_job();
        int c;
        ready_mode = 0;
        eng_stall = 1'b1;
        submit(2, 8'd5, 8'd1, 8'd1, 8'd4, 0, 64'h0);
        c = 0;
        while (!bus.eng_activate && c < 30) begin
            step();
            c++;
        end
        step();
        vectors++;
        if (bus.eng_activate !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_job_reach_run: got act=%b required 1", bus.eng_activate);
        end
        #2 reset = 1'b0;
        #1;
        check_all_zero("reset_mid_job");
        exp_q.delete();
        bus.req_valid = '0;
        rr_ptr = 0; prev_act = 1'b0; stalled = 1'b0; eng_stall = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        submit(1, 8'd0, 8'd2, 8'd0, 8'd9, 1, 64'h20);
        run_until_done("after_reset", 200);
    endtask

    initial begin
        test_reset();
        test_basic_hits();
        test_arbitration();
        test_truncation();
        test_reject();
        test_backpressure();
        test_random();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/search_scheduler.md
Name: search_scheduler

Overview:
- Shares one pattern-search engine (`search`) between NREQ requesters and sequences every job end to end.
- Arbitration is round-robin; each granted job's p/pl/b/bl are latched into the engine.
- The block reset-pulses and activates the engine, re-activates it after each hit to continue from the last address, and streams every match address to a single result port.
- Sits between host-side job sources (UART/command decoder) and the engine instance.

Parameters:
- NREQ, 2, number of requesters (2..4)
- IDW, 2, width of requester id field (clog2 of NREQ, min 1)
- NOMATCH, 8'hFF, engine found value meaning "no further match in block"
- MAX_HITS, 16, hits reported per job before truncation (1..255)
- TIMEOUT, 1023, watchdog cycle limit (used only with optional feature)

Ports:
- CLK100MHZ  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  NREQ  job request per requester, held until accepted
- req_ready  out  NREQ  one-cycle accept strobe, one-hot, to granted requester
- req_p  in  8*NREQ  pattern address, requester i at bits [8i+7:8i]
- req_pl  in  8*NREQ  pattern length
- req_b  in  8*NREQ  block start address
- req_bl  in  8*NREQ  block length
- res_valid  out  1  result record valid
- res_ready  in  1  result consumer ready
- res_id  out  IDW  requester that owns the record
- res_addr  out  8  match address (0 on terminal record)
- res_hit  out  1  1 = match record, 0 = terminal record
- res_last  out  1  1 on terminal record only
- res_trunc  out  1  terminal record: MAX_HITS reached
- res_err  out  1  terminal record: job rejected or timed out
- eng_p, eng_pl, eng_b, eng_bl  out  8 each  engine job registers
- eng_reset  out  1  active-high one-cycle engine restart pulse
- eng_activate  out  1  engine run/continue request
- eng_done  in  1  engine search step complete
- eng_found  in  8  engine match address, valid while eng_done=1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; RR pointer = requester 0; hit counter 0; state IDLE.
- IDLE:
  - Grant the first valid requester at or after ptr+1 (mod NREQ).
  - Pulse req_ready[g] for one cycle, latch its fields and id; ptr <= g.
  - Go to CHECK. No valid request: stay in IDLE.
- CHECK: pl==0, bl==0 or pl>bl -> set err, go to TERM. Otherwise drive eng_* from the latched fields and go to LOAD.
- LOAD: eng_reset=1 for exactly one cycle; hit counter <= 0; next state RUN.
- RUN:
  - eng_activate=1 until eng_done=1 is sampled.
  - On that edge capture eng_found and drop eng_activate.
  - eng_found==NOMATCH -> TERM; otherwise -> HIT.
- HIT:
  - res_valid=1, res_hit=1, res_addr=captured value.
  - On the res_valid & res_ready edge, increment the hit counter.
  - Counter now == MAX_HITS -> set trunc, go to TERM; otherwise -> DRAIN.
- DRAIN: wait for eng_done==0, then go to RUN. Activate is never reasserted while done is still high.
- TERM:
  - res_valid=1, res_hit=0, res_last=1, res_addr=0; trunc/err as latched.
  - On handshake, clear flags and return to IDLE.
  - The arbiter may grant a new job in that same IDLE cycle.
- Result outputs are stable while res_valid=1 and res_ready=0. res_ready is ignored while res_valid=0.
- Exactly one terminal record per accepted job; all hit records precede it. Zero-hit jobs produce only the terminal record.
- req_valid from non-granted requesters is ignored while busy. There is no accept during CHECK..TERM.
- Reset mid-job drops the job: no terminal record, eng_activate=0 immediately (asynchronous).
- Minimum job latency (no hits, engine done in 1 cycle): accept -> terminal res_valid = 4 cycles.

Optional Feature:
- Macro SEARCH_TIMEOUT_EN.
- Defined: a watchdog counts cycles in RUN and DRAIN, cleared on every state entry. Reaching TIMEOUT forces eng_activate=0, sets err and goes to TERM.
- Undefined: no counter; RUN and DRAIN wait indefinitely, and res_err is set only by CHECK rejection.

Test Plan:
- Req0 p=0 pl=2 b=0 bl=20; engine model returns 5, 12, FF; res_ready=1 -> records (0,5,hit), (0,12,hit), then terminal last=1 trunc=0 err=0; eng_reset pulsed once.
- Req0 and req1 valid together, ptr=0 -> req1 granted first, then req0. Terminal record ids are 1 then 0; req_ready is never two-hot.
- MAX_HITS=2, engine returns 3, 4, 9 -> two hit records, then terminal trunc=1; the third activate is never issued.
- Req with pl=5 bl=3 -> terminal err=1 with no eng_reset or eng_activate; pl=0 also gives err=1.
- res_ready held 0 for 10 cycles on the hit record at addr 7 -> res_addr stays 7 and eng_activate stays 0 throughout. Reset asserted in RUN -> all outputs 0, busy=0.
- With SEARCH_TIMEOUT_EN and TIMEOUT=15, eng_done held 0 -> terminal err=1 in cycle 15 after RUN entry.
